// File: rtl/packet_framer.sv
// Message-to-word framer: a two-word header (length/stream, sequence number)
// followed by the payload, serialized as 32-bit words under valid/ready.
module packet_framer #(
    parameter int MAX_BYTES   = 37,
    parameter int NUM_STREAMS = 32
) (
    input  logic                     clk,
    input  logic                     reset_b,
    input  logic [0:8*MAX_BYTES-1]   msgIn,
    input  logic [5:0]               msgIn_len,
    input  logic [15:0]              msgIn_stream,
    input  logic                     msgIn_val,
    output logic                     msgIn_ready,
    output logic [31:0]              dataOut,
    output logic                     dataOut_val,
    input  logic                     dataOut_ready,
    output logic                     dataOut_last,
    output logic                     msgErr
);

    localparam int PAD_BYTES = ((MAX_BYTES + 3) / 4) * 4;
    localparam int IDX_W     = $clog2(NUM_STREAMS);
    localparam int WIDX_W    = $clog2(PAD_BYTES / 4);

    typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;

    state_t                   state_q;
    logic                     ready_q, val_q, last_q, err_q;
    logic [31:0]              dataOut_q;
    logic [WIDX_W-1:0]        widx_q;
    logic [31:0]              seq_q [NUM_STREAMS];

    logic [0:8*PAD_BYTES-1]   payload_q, payload_d;
    logic [IDX_W-1:0]         sidx_q;
    logic [WIDX_W-1:0]        wlast_q, wlast_d;

    logic                     accept, len_ok, xfer;
    logic [15:0]              hdr_len;
    logic [31:0]              seq_nxt, hdr0_word, hdr1_word, word_nxt;
    logic [WIDX_W-1:0]        nidx;

    assign accept    = msgIn_val & ready_q;
    assign len_ok    = (msgIn_len != 6'd0) && (msgIn_len <= 6'(MAX_BYTES));
    assign xfer      = val_q & dataOut_ready;
    assign hdr_len   = 16'(msgIn_len) + 16'd8;
    assign hdr0_word = {hdr_len[7:0], hdr_len[15:8], msgIn_stream[7:0], msgIn_stream[15:8]};
    assign seq_nxt   = seq_q[sidx_q] + 32'd1;
    assign hdr1_word = {seq_nxt[7:0], seq_nxt[15:8], seq_nxt[23:16], seq_nxt[31:24]};
    assign wlast_d   = WIDX_W'((msgIn_len - 6'd1) >> 2);
    assign nidx      = (state_q == DATA) ? widx_q + 1'b1 : '0;
    assign word_nxt  = payload_q[32*nidx +: 32];

    // Bytes beyond the message length are zeroed at capture so data words need no masking.
    always_comb begin
        payload_d = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (6'(k) < msgIn_len) payload_d[8*k +: 8] = msgIn[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (accept && len_ok) begin
            payload_q <= payload_d;
            sidx_q    <= msgIn_stream[IDX_W-1:0];
            wlast_q   <= wlast_d;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            val_q     <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            dataOut_q <= '0;
            widx_q    <= '0;
            for (int s = 0; s < NUM_STREAMS; s++) seq_q[s] <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (len_ok) begin
                            state_q   <= HDR0;
                            ready_q   <= 1'b0;
                            val_q     <= 1'b1;
                            dataOut_q <= hdr0_word;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                HDR0: if (xfer) begin
                    state_q   <= HDR1;
                    dataOut_q <= hdr1_word;
                end
                HDR1: if (xfer) begin
                    state_q   <= DATA;
                    widx_q    <= '0;
                    dataOut_q <= word_nxt;
                    last_q    <= (wlast_q == '0);
                end
                DATA: if (xfer) begin
                    if (last_q) begin
                        // Counter commits only once the whole packet has left.
                        seq_q[sidx_q] <= seq_nxt;
                        state_q       <= IDLE;
                        ready_q       <= 1'b1;
                        val_q         <= 1'b0;
                        last_q        <= 1'b0;
                        dataOut_q     <= '0;
                    end else begin
                        widx_q    <= widx_q + 1'b1;
                        dataOut_q <= word_nxt;
                        last_q    <= (nidx == wlast_q);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign msgIn_ready  = ready_q;
    assign dataOut      = dataOut_q;
    assign dataOut_val  = val_q;
    assign dataOut_last = last_q;
    assign msgErr       = err_q;

endmodule

// File: tb/tb_packet_framer.sv
// Randomized bench for packet_framer against a queue-based packet model.
module tb_packet_framer;

    logic          clk = 1'b0;
    logic          reset_b;
    logic [0:295]  msgIn;
    logic [5:0]    msgIn_len;
    logic [15:0]   msgIn_stream;
    logic          msgIn_val;
    logic          msgIn_ready;
    logic [31:0]   dataOut;
    logic          dataOut_val;
    logic          dataOut_ready;
    logic          dataOut_last;
    logic          msgErr;

    packet_framer #(.MAX_BYTES(37), .NUM_STREAMS(32)) dut (
        .clk(clk), .reset_b(reset_b),
        .msgIn(msgIn), .msgIn_len(msgIn_len), .msgIn_stream(msgIn_stream),
        .msgIn_val(msgIn_val), .msgIn_ready(msgIn_ready),
        .dataOut(dataOut), .dataOut_val(dataOut_val), .dataOut_ready(dataOut_ready),
        .dataOut_last(dataOut_last), .msgErr(msgErr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   pay [37];
    int unsigned  seq_m [32];
    int unsigned  exp_seq;
    logic [31:0]  exp_w [$];
    logic [31:0]  obs_w [$];
    logic         obs_l [$];
    int           cyc, hold_viol;
    logic         tmo, lat_ok;
    logic         rdy_pat [8];

    task automatic randomize_payload();
        for (int k = 0; k < 37; k++) pay[k] = 8'($urandom);
    endtask

    // Expected words built straight from the framing rules.
    function automatic void build_exp(input logic [15:0] stream, input int len);
        int L;
        logic [31:0] s;
        logic [31:0] w;
        exp_w.delete();
        L = len + 8;
        exp_w.push_back({8'(L % 256), 8'(L / 256), stream[7:0], stream[15:8]});
        exp_seq = seq_m[int'(stream) % 32] + 1;
        s = exp_seq;
        exp_w.push_back({s[7:0], s[15:8], s[23:16], s[31:24]});
        for (int i = 0; i < (len + 3) / 4; i++) begin
            w = 0;
            for (int b = 0; b < 4; b++) w = (w << 8) | ((4*i + b < len) ? 32'(pay[4*i + b]) : 32'd0);
            exp_w.push_back(w);
        end
    endfunction

    // mode 0: ready always high, 1: random ready, 2: rdy_pat then high.
    task automatic drive_packet(input logic [15:0] stream, input logic [5:0] len, input int mode);
        int guard;
        logic rdy, prev_stall, prev_l, done;
        logic [31:0] prev_w;
        obs_w.delete(); obs_l.delete();
        cyc = 0; hold_viol = 0; tmo = 1'b0; lat_ok = 1'b0;
        guard = 0;
        while (!msgIn_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) begin
            tmo = 1'b1;
            return;
        end
        for (int k = 0; k < 37; k++) msgIn[8*k +: 8] = pay[k];
        msgIn_len = len; msgIn_stream = stream; msgIn_val = 1'b1;
        @(posedge clk); #1;
        msgIn_val = 1'b0;
        for (int k = 0; k < 37; k++) msgIn[8*k +: 8] = 8'($urandom);
        msgIn_len = 6'($urandom); msgIn_stream = 16'($urandom);
        lat_ok = dataOut_val;
        prev_stall = 1'b0; prev_w = '0; prev_l = 1'b0;
        guard = 0;
        while (guard < 400) begin
            if (mode == 1) rdy = 1'($urandom);
            else if (mode == 2 && cyc < 8) rdy = rdy_pat[cyc];
            else rdy = 1'b1;
            dataOut_ready = rdy;
            if (!dataOut_val) begin
                hold_viol++;
                break;
            end
            if (prev_stall && (dataOut !== prev_w || dataOut_last !== prev_l)) hold_viol++;
            if (rdy) begin
                obs_w.push_back(dataOut);
                obs_l.push_back(dataOut_last);
            end
            prev_stall = !rdy; prev_w = dataOut; prev_l = dataOut_last;
            done = rdy && dataOut_last;
            @(posedge clk); #1;
            cyc++; guard++;
            if (done) break;
        end
        if (guard >= 400) tmo = 1'b1;
        dataOut_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (msgIn_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", msgIn_ready); end
        n_checks++; if (dataOut_val !== 1'b0) begin n_fail++; $display("FAIL reset_val: got %b want 0", dataOut_val); end
        n_checks++; if (dataOut !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", dataOut); end
        n_checks++; if (dataOut_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", dataOut_last); end
        n_checks++; if (msgErr !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", msgErr); end
        reset_b = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (msgIn_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", msgIn_ready); end
        for (int s = 0; s < 32; s++) seq_m[s] = 0;
    endtask

    task automatic test_vector();
        logic [31:0] want [4];
        want[0] = 32'h0D000300; want[1] = 32'h01000000; want[2] = 32'h11223344; want[3] = 32'h55000000;
        randomize_payload();
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44; pay[4] = 8'h55;
        drive_packet(16'd3, 6'd5, 0);
        n_checks++; if (tmo || !lat_ok) begin n_fail++; $display("FAIL vec_latency: tmo %b first_val %b want 0/1", tmo, lat_ok); end
        n_checks++; if (obs_w.size() != 4 || cyc != 4) begin n_fail++; $display("FAIL vec_count: words %0d cycles %0d want 4/4", obs_w.size(), cyc); end
        for (int i = 0; i < 4 && i < obs_w.size(); i++) begin
            n_checks++;
            if (obs_w[i] !== want[i] || obs_l[i] !== (i == 3)) begin
                n_fail++; $display("FAIL vec_word%0d: got %h last %b want %h last %b", i, obs_w[i], obs_l[i], want[i], i == 3);
            end
        end
        n_checks++;
        if (dataOut_val !== 1'b0 || dataOut !== 32'h0 || dataOut_last !== 1'b0 || msgIn_ready !== 1'b1) begin
            n_fail++; $display("FAIL vec_idle: val %b data %h last %b ready %b want 0/0/0/1", dataOut_val, dataOut, dataOut_last, msgIn_ready);
        end
        seq_m[3] = 1;
    endtask

    task automatic test_max_len();
        randomize_payload();
        pay[36] = 8'hA5;
        build_exp(16'd3, 37);
        drive_packet(16'd3, 6'd37, 0);
        n_checks++; if (obs_w.size() != 12 || cyc != 12 || tmo) begin n_fail++; $display("FAIL max_count: words %0d cycles %0d want 12/12", obs_w.size(), cyc); end
        n_checks++; if (obs_w.size() > 1 && (obs_w[0] !== 32'h2D000300 || obs_w[1] !== 32'h02000000)) begin
            n_fail++; $display("FAIL max_hdr: got %h %h want 2d000300 02000000", obs_w[0], obs_w[1]);
        end
        n_checks++; if (obs_w.size() == 12 && obs_w[11] !== 32'hA5000000) begin n_fail++; $display("FAIL max_tail: got %h want a5000000", obs_w[11]); end
        for (int i = 0; i < exp_w.size(); i++) begin
            n_checks++;
            if (i >= obs_w.size() || obs_w[i] !== exp_w[i] || obs_l[i] !== (i == exp_w.size() - 1)) begin
                n_fail++; $display("FAIL max_word%0d: got %h want %h", i, (i < obs_w.size()) ? obs_w[i] : 32'hx, exp_w[i]);
            end
        end
        seq_m[3] = exp_seq;
    endtask

    task automatic test_len_error();
        int seen_val;
        logic [5:0] bad [2];
        bad[0] = 6'd0; bad[1] = 6'd38;
        seen_val = 0;
        for (int j = 0; j < 2; j++) begin
            msgIn_len = bad[j]; msgIn_stream = 16'd3; msgIn_val = 1'b1;
            @(posedge clk); #1;
            msgIn_val = 1'b0;
            if (dataOut_val) seen_val++;
            n_checks++; if (msgErr !== 1'b1 || msgIn_ready !== 1'b1) begin n_fail++; $display("FAIL err_pulse%0d: err %b ready %b want 1/1", j, msgErr, msgIn_ready); end
            @(posedge clk); #1;
            if (dataOut_val) seen_val++;
            n_checks++; if (msgErr !== 1'b0) begin n_fail++; $display("FAIL err_clear%0d: got %b want 0", j, msgErr); end
        end
        n_checks++; if (seen_val != 0) begin n_fail++; $display("FAIL err_noval: got %0d valid cycles want 0", seen_val); end
        randomize_payload();
        drive_packet(16'd3, 6'd2, 0);
        n_checks++; if (obs_w.size() != 3 || obs_w[1] !== 32'h03000000) begin
            n_fail++; $display("FAIL err_seq: words %0d hdr1 %h want 3 words hdr1 03000000", obs_w.size(), (obs_w.size() > 1) ? obs_w[1] : 32'hx);
        end
        seq_m[3] = 3;
    endtask

    task automatic test_backpressure();
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
        for (int i = 4; i < 8; i++) rdy_pat[i] = 1'b1;
        randomize_payload();
        build_exp(16'd3, 5);
        drive_packet(16'd3, 6'd5, 2);
        n_checks++; if (hold_viol != 0 || tmo || cyc != 6) begin n_fail++; $display("FAIL bp_hold: violations %0d cycles %0d want 0/6", hold_viol, cyc); end
        n_checks++; if (obs_w.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", obs_w.size()); end
        for (int i = 0; i < exp_w.size(); i++) begin
            n_checks++;
            if (i >= obs_w.size() || obs_w[i] !== exp_w[i] || obs_l[i] !== (i == exp_w.size() - 1)) begin
                n_fail++; $display("FAIL bp_word%0d: got %h want %h", i, (i < obs_w.size()) ? obs_w[i] : 32'hx, exp_w[i]);
            end
        end
        seq_m[3] = exp_seq;
    endtask

    task automatic test_reset_mid();
        int seen_val;
        randomize_payload();
        for (int k = 0; k < 37; k++) msgIn[8*k +: 8] = pay[k];
        msgIn_len = 6'd20; msgIn_stream = 16'd7; msgIn_val = 1'b1; dataOut_ready = 1'b1;
        @(posedge clk); #1;
        msgIn_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (dataOut_val !== 1'b1 || dataOut_last !== 1'b0) begin n_fail++; $display("FAIL mid_active: val %b last %b want 1/0", dataOut_val, dataOut_last); end
        #2 reset_b = 1'b0;
        #1;
        n_checks++; if (dataOut_val !== 1'b0 || dataOut !== 32'h0 || msgIn_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_async: val %b data %h ready %b want 0/0/0", dataOut_val, dataOut, msgIn_ready);
        end
        @(posedge clk); #1;
        reset_b = 1'b1;
        seen_val = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (dataOut_val) seen_val++;
        end
        n_checks++; if (seen_val != 0 || msgIn_ready !== 1'b1) begin n_fail++; $display("FAIL mid_quiet: valid cycles %0d ready %b want 0/1", seen_val, msgIn_ready); end
        for (int s = 0; s < 32; s++) seq_m[s] = 0;
        drive_packet(16'd7, 6'd20, 0);
        n_checks++; if (obs_w.size() != 7 || obs_w[1] !== 32'h01000000) begin
            n_fail++; $display("FAIL mid_resend: words %0d hdr1 %h want 7 words hdr1 01000000", obs_w.size(), (obs_w.size() > 1) ? obs_w[1] : 32'hx);
        end
        seq_m[7] = 1;
        randomize_payload();
        drive_packet(16'h0027, 6'd3, 0);
        n_checks++; if (obs_w.size() != 3 || obs_w[0] !== 32'h0B002700 || obs_w[1] !== 32'h02000000) begin
            n_fail++; $display("FAIL mid_shared: hdr0 %h hdr1 %h want 0b002700 02000000", (obs_w.size() > 0) ? obs_w[0] : 32'hx, (obs_w.size() > 1) ? obs_w[1] : 32'hx);
        end
        seq_m[7] = 2;
    endtask

    task automatic test_wrap();
        dut.seq_q[0] = 32'hFFFF_FFFF;
        seq_m[0] = 32'hFFFF_FFFF;
        randomize_payload();
        drive_packet(16'h0000, 6'd4, 0);
        n_checks++; if (obs_w.size() != 3 || obs_w[1] !== 32'h00000000) begin
            n_fail++; $display("FAIL wrap_hdr1: got %h want 00000000", (obs_w.size() > 1) ? obs_w[1] : 32'hx);
        end
        seq_m[0] = 0;
        drive_packet(16'h0020, 6'd4, 0);
        n_checks++; if (obs_w.size() != 3 || obs_w[1] !== 32'h01000000) begin
            n_fail++; $display("FAIL wrap_stored: got %h want 01000000", (obs_w.size() > 1) ? obs_w[1] : 32'hx);
        end
        seq_m[0] = 1;
    endtask

    task automatic test_random();
        logic [15:0] stream;
        int len, mode;
        for (int n = 0; n < 24; n++) begin
            stream = 16'($urandom);
            len = $urandom_range(1, 37);
            mode = $urandom_range(0, 1);
            randomize_payload();
            build_exp(stream, len);
            drive_packet(stream, 6'(len), mode);
            n_checks++;
            if (tmo || !lat_ok || hold_viol != 0 || obs_w.size() != exp_w.size() || (mode == 0 && cyc != exp_w.size())) begin
                n_fail++; $display("FAIL rand%0d_proto: words %0d want %0d cycles %0d holdviol %0d", n, obs_w.size(), exp_w.size(), cyc, hold_viol);
            end
            for (int i = 0; i < exp_w.size(); i++) begin
                n_checks++;
                if (i >= obs_w.size() || obs_w[i] !== exp_w[i] || obs_l[i] !== (i == exp_w.size() - 1)) begin
                    n_fail++; $display("FAIL rand%0d_word%0d: got %h want %h", n, i, (i < obs_w.size()) ? obs_w[i] : 32'hx, exp_w[i]);
                end
            end
            seq_m[int'(stream) % 32] = exp_seq;
        end
    endtask

    initial begin
        reset_b = 1'b0; msgIn = '0; msgIn_len = '0; msgIn_stream = '0;
        msgIn_val = 1'b0; dataOut_ready = 1'b1;
        test_reset();
        test_vector();
        test_max_len();
        test_len_error();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
